// File: rtl/rca_seq.sv
// rtl/rca_seq.sv - multi-precision adder sequencer over one shared 4-bit ripple-carry adder
// Optional subtract mode (sub port, A - B) is enabled by defining RCA_SEQ_SUB_EN.

module rca4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[4];

endmodule

module rca_seq #(
  parameter int NIBBLES = 4,
  parameter int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;

  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_b;
  logic [3:0]      w_nib_sum;
  logic            w_nib_cout;

  assign w_nib_a = r_a[4*r_idx +: 4];
  assign w_nib_b = r_b[4*r_idx +: 4];

  rca4 u_rca4 (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  // Subtraction stores ~B and seeds the carry with 1, so RUN is identical for both modes.
  logic [W-1:0] w_b_in;
  logic         w_carry_in;
`ifdef RCA_SEQ_SUB_EN
  assign w_b_in     = sub ? ~b : b;
  assign w_carry_in = sub ? 1'b1 : cin;
`else
  assign w_b_in     = b;
  assign w_carry_in = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_carry_in;
            r_sum   <= '0;
            r_idx   <= '0;
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_sum[4*r_idx +: 4] <= w_nib_sum;
          r_carry             <= w_nib_cout;
          r_idx               <= r_idx + IDXW'(1);
          if (r_idx == LAST) begin
            r_cout  <= w_nib_cout;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_rca_seq.sv
// tb/tb_rca_seq.sv - self-checking bench for rca_seq (NIBBLES=4 and NIBBLES=1 instances)
// Define RCA_SEQ_SUB_EN to also exercise the subtract mode.

module tb_rca_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  logic        s1_start;
  logic [3:0]  s1_a;
  logic [3:0]  s1_b;
  logic        s1_cin;
  logic        s1_ready;
  logic        s1_busy;
  logic        s1_done;
  logic [3:0]  s1_sum;
  logic        s1_cout;

`ifdef RCA_SEQ_SUB_EN
  logic        sub;
  logic        s1_sub;
`endif

  int checks = 0;
  int errors = 0;

  rca_seq #(.NIBBLES(4)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  rca_seq #(.NIBBLES(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (s1_start),
    .a     (s1_a),
    .b     (s1_b),
    .cin   (s1_cin),
`ifdef RCA_SEQ_SUB_EN
    .sub   (s1_sub),
`endif
    .ready (s1_ready),
    .busy  (s1_busy),
    .done  (s1_done),
    .sum   (s1_sum),
    .cout  (s1_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no nibble slicing.
  function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    logic [16:0] r;
    if (msub) r = {1'b0, ma} - {1'b0, mb} + 17'h10000;
    else      r = {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
    return r;
  endfunction

  task automatic do_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                       input logic vcin, input logic vsub,
                       input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    int bad;
    bit seen;
    logic [15:0] held;
    lat  = 0;
    bad  = 0;
    seen = 0;
    for (int k = 0; k < 20 && ready !== 1'b1; k++) @(negedge clk);
    chk({name, "_ready_before"}, {31'd0, ready}, 32'd1);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vcin;
`ifdef RCA_SEQ_SUB_EN
    sub   = vsub;
`else
    if (vsub) $display("note: sub vector skipped in add-only build");
`endif
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom_range(0, 1));
      end
      lat++;
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy !== 1'b1 || ready !== 1'b0) bad++;
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_latency"}, lat, 32'd5);
    chk({name, "_busy_run"}, bad, 32'd0);
    chk({name, "_done_flags"}, {30'd0, busy, ready}, 32'd0);
    chk({name, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
    chk({name, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    held = sum;
    @(negedge clk);
    chk({name, "_after_done"}, {30'd0, done, ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk({name, "_hold"}, {15'd0, cout, sum}, {15'd0, exp_cout, held});
  endtask

  initial begin
    int dones;
    logic [16:0] m;
    logic [15:0] ra, rb;
    logic        rc, rs;

    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    s1_start = 1'b0;
    s1_a     = '0;
    s1_b     = '0;
    s1_cin   = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub      = 1'b0;
    s1_sub   = 1'b0;
`endif

    vecs.push_back('{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h8888, 16'h8888, 1'b0, 1'b0, 16'h1110, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0});
`ifdef RCA_SEQ_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset_sum_cout", {15'd0, cout, sum}, 32'd0);
    chk("reset1_state", {28'd0, s1_ready, s1_busy, s1_done, s1_cout}, 32'h8);

    for (int i = 0; i < vecs.size(); i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].exp_sum, vecs[i].exp_cout);

    // start held high with new operands during RUN must not disturb the operation
    start = 1'b1;
    a     = 16'h00FF;
    b     = 16'h0001;
    cin   = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub   = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    a     = 16'h1111;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) start = 1'b0;
      if (done === 1'b1) dones++;
    end
    chk("ign_dones", dones, 32'd1);
    chk("ign_sum", {16'd0, sum}, 32'h0100);
    chk("ign_cout", {31'd0, cout}, 32'd0);
    chk("ign_ready", {31'd0, ready}, 32'd1);

    // reset on the 2nd RUN edge
    start = 1'b1;
    a     = 16'h8888;
    b     = 16'h8888;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_flags", {29'd0, ready, busy, done}, 32'h4);
    chk("rst_mid_sum_cout", {15'd0, cout, sum}, 32'd0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("rst_mid_no_done", dones, 32'd0);
    do_op("after_rst", 16'h8888, 16'h8888, 1'b0, 1'b0, 16'h1110, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
`ifdef RCA_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
      m = model(ra, rb, rc, rs);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, m[15:0], m[16]);
    end

    // NIBBLES=1 instance
    for (int i = 0; i < 3; i++) begin
      int lat;
      logic [3:0] ea, eb, es;
      logic ec, ecout;
      case (i)
        0:       begin ea = 4'h9; eb = 4'h8; ec = 1'b1; es = 4'h2; ecout = 1'b1; end
        1:       begin ea = 4'hF; eb = 4'h0; ec = 1'b1; es = 4'h0; ecout = 1'b1; end
        default: begin ea = 4'h3; eb = 4'h4; ec = 1'b0; es = 4'h7; ecout = 1'b0; end
      endcase
      s1_start = 1'b1;
      s1_a     = ea;
      s1_b     = eb;
      s1_cin   = ec;
      lat      = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge clk);
        @(negedge clk);
        s1_start = 1'b0;
        lat++;
        if (s1_done === 1'b1) break;
      end
      chk($sformatf("n1_%0d_latency", i), lat, 32'd2);
      chk($sformatf("n1_%0d_sum", i), {28'd0, s1_sum}, {28'd0, es});
      chk($sformatf("n1_%0d_cout", i), {31'd0, s1_cout}, {31'd0, ecout});
      @(negedge clk);
      chk($sformatf("n1_%0d_ready", i), {30'd0, s1_ready, s1_done}, 32'h2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
